r3_sdf_stage_ctrl: RTL and testbench
====================================

Name: r3_sdf_stage_ctrl

Overview:
Sequencing controller for one radix-3 single-delay-feedback (SDF) stage of the radix-3^2 FFT pipeline.
- Counts input samples per frame and selects fill/compute phases for the two feedback delay lines.
- Generates butterfly enable, feedback write enable, twiddle index and the valid/pad bits that travel alongside data through the fixed delay buffers.
- Handles end-of-stream flush so buffered butterfly legs are drained without further input.

Parameters:
D, 9, feedback delay length per leg (N/3 of this stage); frame length is 3*D
CW, 5, sample counter width; must satisfy 2^CW >= 3*D
TW_W, 5, twiddle index width; must satisfy 2^TW_W >= 3*D

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  upstream sample valid this cycle
flush  input  1  end-of-stream request, sampled each cycle
phase  output  2  0/1 = fill legs, 2 = compute
bf_en  output  1  butterfly computes this cycle
fb_wr_en  output  1  feedback delay lines shift this cycle
tw_idx  output  TW_W  twiddle exponent for current output sample
tw_mult_en  output  1  twiddle multiply required (leg != 0)
out_valid  output  1  stage output sample valid; drives delay-line valid bit
pad_zero  output  1  datapath substitutes zero for input sample
frame_start  output  1  one-cycle pulse, first sample of frame
frame_done  output  1  one-cycle pulse, last sample of frame
busy  output  1  state != IDLE
drop_cnt  output  8  dropped-sample count (see Optional Feature)

Behaviour:
- Reset: all outputs 0, cnt=0, has_prev=0, wrapped=0, state IDLE.
- All outputs registered; they describe the sample presented at the previous edge (1-cycle latency, matching datapath input register).
- adv = (state==RUN & in_valid) | (state==IDLE & in_valid) | (state==DRAIN). Counter and delay lines move only on adv.
- cnt runs 0..3D-1 on adv; at 3D-1 it wraps to 0, pulses frame_done, and sets has_prev=1.
- phase = 0 if cnt<D, 1 if cnt<2D, else 2. fb_wr_en = adv. bf_en = adv & phase==2.
- Output leg k: phase2 -> k=0 (direct), phase0 -> k=1, phase1 -> k=2 (legs 1 and 2 from previous frame). n = cnt mod D.
- tw_idx = (n*k) mod 3D. tw_mult_en = out_valid & k!=0.
- out_valid = adv & (phase==2 | has_prev).
- frame_start pulses on adv with cnt==0 and state!=DRAIN.
- FSM:
  - IDLE: first in_valid -> RUN; that sample is accepted with cnt=0.
  - RUN: flush with cnt!=0 -> DRAIN, wrapped=0. flush with cnt==0 & has_prev -> DRAIN, wrapped=1. flush with cnt==0 & !has_prev -> IDLE.
  - DRAIN: advances every cycle with pad_zero=1. On wrap 3D-1->0, wrapped=1. When wrapped & cnt reaches 2D-1 -> IDLE; cnt=0, has_prev=0, wrapped=0.
- flush and in_valid in the same RUN cycle: the sample is accepted first, then the flush transition applies.
- in_valid during DRAIN: sample dropped; no counter effect beyond normal drain.
- in_valid low in RUN: all state holds; out_valid=0 and bf_en=0 (stall).
- rst mid-frame: immediate return to reset values; buffered legs are discarded.

Optional Feature:
R3_CTRL_DROP_CNT_EN
- Defined: drop_cnt is an 8-bit saturating count of in_valid cycles seen in DRAIN. Saturates at 255. Cleared only by rst.
- Undefined: drop_cnt tied to 0; no counter logic.

Test Plan:
- D=9, 27 continuous in_valid -> phase 0 for 9, 1 for 9, 2 for 9; bf_en high 9 cycles; out_valid high only on those 9; frame_done pulses once; has_prev=1.
- Two back-to-back frames (54 samples) -> out_valid continuous from sample 19 onward; tw_idx in frame 2 phase0 = 0,1,..,8; phase1 = 0,2,4,..,16.
- In_valid deasserted 3 cycles at cnt=12 -> cnt holds 12; outputs bf_en=0, out_valid=0; resumes at 13.
- Flush at cnt=5 of frame 2 -> 22 pad cycles to wrap, then 18 more; busy drops after sample cnt=17; 27+18 out_valid totals correct.
- Flush coincident with cnt==0 and no prior frame -> direct IDLE, busy=0, no out_valid.
- rst asserted at cnt=20 -> all outputs 0 immediately. With R3_CTRL_DROP_CNT_EN, 4 in_valid during DRAIN -> drop_cnt=4.

Source files
------------

// File: rtl/r3_sdf_stage_ctrl.sv
// rtl/r3_sdf_stage_ctrl.sv - radix-3 SDF stage sequencer (fill/compute phases, twiddle index, flush drain)
// Optional feature macro: R3_CTRL_DROP_CNT_EN (saturating count of samples dropped while draining)
module r3_sdf_stage_ctrl #(
    parameter int D    = 9,
    parameter int CW   = 5,
    parameter int TW_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic            flush,
    output logic [1:0]      phase,
    output logic            bf_en,
    output logic            fb_wr_en,
    output logic [TW_W-1:0] tw_idx,
    output logic            tw_mult_en,
    output logic            out_valid,
    output logic            pad_zero,
    output logic            frame_start,
    output logic            frame_done,
    output logic            busy,
    output logic [7:0]      drop_cnt
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [CW-1:0] D_C    = CW'(D);
    localparam logic [CW-1:0] D2_C   = CW'(2 * D);
    localparam logic [CW-1:0] MID_C  = CW'(2 * D - 1);
    localparam logic [CW-1:0] LAST_C = CW'(3 * D - 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d, cnt_nx;
    logic            has_prev_q, has_prev_d, hp_nx;
    logic            wrapped_q, wrapped_d;
    logic [1:0]      phase_q, phase_d;
    logic            bf_en_q, bf_en_d, fb_wr_en_q, fb_wr_en_d;
    logic [TW_W-1:0] tw_idx_q, tw_idx_d;
    logic            tw_mult_en_q, tw_mult_en_d, out_valid_q, out_valid_d;
    logic            pad_zero_q, pad_zero_d, frame_start_q, frame_start_d;
    logic            frame_done_q, frame_done_d, busy_q, busy_d;
    logic            adv, wrap;
    logic [1:0]      k;
    logic [CW-1:0]   n_c;
    logic [TW_W-1:0] n;

    always_comb begin
        adv = (state_q == DRAIN) | in_valid;
        // Legs 1 and 2 of the previous frame leave while the current frame fills
        if (cnt_q < D_C) begin
            phase_d = 2'd0; k = 2'd1; n_c = cnt_q;
        end else if (cnt_q < D2_C) begin
            phase_d = 2'd1; k = 2'd2; n_c = cnt_q - D_C;
        end else begin
            phase_d = 2'd2; k = 2'd0; n_c = cnt_q - D2_C;
        end
        n = TW_W'(n_c);
        case (k)
            2'd1:    tw_idx_d = n;
            2'd2:    tw_idx_d = n << 1;
            default: tw_idx_d = '0;
        endcase

        wrap   = adv && (cnt_q == LAST_C);
        cnt_nx = adv ? (wrap ? '0 : cnt_q + 1'b1) : cnt_q;
        hp_nx  = has_prev_q | wrap;

        out_valid_d   = adv & ((phase_d == 2'd2) | has_prev_q);
        tw_mult_en_d  = out_valid_d & (k != 2'd0);
        bf_en_d       = adv & (phase_d == 2'd2);
        fb_wr_en_d    = adv;
        pad_zero_d    = (state_q == DRAIN);
        frame_start_d = adv && (cnt_q == '0) && (state_q != DRAIN);
        frame_done_d  = wrap;

        state_d    = state_q;
        cnt_d      = cnt_nx;
        has_prev_d = hp_nx;
        wrapped_d  = wrapped_q;
        case (state_q)
            IDLE, RUN: begin
                if (in_valid) state_d = RUN;
                // Flush is judged against the count after this cycle's sample is taken
                if (flush) begin
                    if (cnt_nx != '0) begin
                        state_d = DRAIN; wrapped_d = 1'b0;
                    end else if (hp_nx) begin
                        state_d = DRAIN; wrapped_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                if (wrap) wrapped_d = 1'b1;
                if (wrapped_q && (cnt_q == MID_C)) begin
                    state_d    = IDLE;
                    cnt_d      = '0;
                    has_prev_d = 1'b0;
                    wrapped_d  = 1'b0;
                end
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            has_prev_q    <= 1'b0;
            wrapped_q     <= 1'b0;
            phase_q       <= '0;
            bf_en_q       <= 1'b0;
            fb_wr_en_q    <= 1'b0;
            tw_idx_q      <= '0;
            tw_mult_en_q  <= 1'b0;
            out_valid_q   <= 1'b0;
            pad_zero_q    <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            has_prev_q    <= has_prev_d;
            wrapped_q     <= wrapped_d;
            phase_q       <= phase_d;
            bf_en_q       <= bf_en_d;
            fb_wr_en_q    <= fb_wr_en_d;
            tw_idx_q      <= tw_idx_d;
            tw_mult_en_q  <= tw_mult_en_d;
            out_valid_q   <= out_valid_d;
            pad_zero_q    <= pad_zero_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            busy_q        <= busy_d;
        end
    end

`ifdef R3_CTRL_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if ((state_q == DRAIN) && in_valid && (drop_cnt_q != 8'hFF))
            drop_cnt_d = drop_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) drop_cnt_q <= '0;
        else     drop_cnt_q <= drop_cnt_d;
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign drop_cnt = '0;
`endif

    assign phase       = phase_q;
    assign bf_en       = bf_en_q;
    assign fb_wr_en    = fb_wr_en_q;
    assign tw_idx      = tw_idx_q;
    assign tw_mult_en  = tw_mult_en_q;
    assign out_valid   = out_valid_q;
    assign pad_zero    = pad_zero_q;
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;
    assign busy        = busy_q;
endmodule

// File: tb/tb_r3_sdf_stage_ctrl.sv
// tb/tb_r3_sdf_stage_ctrl.sv - directed-vector bench for r3_sdf_stage_ctrl (D=9)
module tb_r3_sdf_stage_ctrl;
    localparam int D = 9;
`ifdef R3_CTRL_DROP_CNT_EN
    localparam int EXP_DROP = 4;
`else
    localparam int EXP_DROP = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       flush = 1'b0;
    logic [1:0] phase;
    logic       bf_en, fb_wr_en, tw_mult_en, out_valid, pad_zero;
    logic       frame_start, frame_done, busy;
    logic [4:0] tw_idx;
    logic [7:0] drop_cnt;

    int vec_cnt = 0;
    int err_cnt = 0;
    int ov_total, bf_total, fd_total;

    always #5 clk = ~clk;

    r3_sdf_stage_ctrl #(.D(D), .CW(5), .TW_W(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .flush(flush),
        .phase(phase), .bf_en(bf_en), .fb_wr_en(fb_wr_en), .tw_idx(tw_idx),
        .tw_mult_en(tw_mult_en), .out_valid(out_valid), .pad_zero(pad_zero),
        .frame_start(frame_start), .frame_done(frame_done), .busy(busy),
        .drop_cnt(drop_cnt)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input logic v, input logic f);
        @(negedge clk);
        in_valid = v;
        flush    = f;
        @(posedge clk);
        #1;
    endtask

    // Expected twiddle for sample count c: leg 1 in the first third, leg 2 in the second, leg 0 last
    function automatic int exp_tw(input int c);
        int k;
        k = (c < D) ? 1 : (c < 2 * D) ? 2 : 0;
        return (c % D) * k;
    endfunction

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_phase"}, phase, 0);
        check_eq({tag, "_bf"}, bf_en, 0);
        check_eq({tag, "_fb"}, fb_wr_en, 0);
        check_eq({tag, "_tw"}, tw_idx, 0);
        check_eq({tag, "_twm"}, tw_mult_en, 0);
        check_eq({tag, "_ov"}, out_valid, 0);
        check_eq({tag, "_pad"}, pad_zero, 0);
        check_eq({tag, "_fs"}, frame_start, 0);
        check_eq({tag, "_fd"}, frame_done, 0);
        check_eq({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        check_eq("reset_drop", drop_cnt, 0);
        @(negedge clk);
        rst = 1'b0;

        // Frame 1: no previous frame, only the compute third produces output
        ov_total = 0; bf_total = 0; fd_total = 0;
        for (int i = 0; i < 3 * D; i++) begin
            step(1'b1, 1'b0);
            check_eq("f1_phase", phase, i / D);
            check_eq("f1_ov", out_valid, (i >= 2 * D) ? 1 : 0);
            check_eq("f1_fs", frame_start, (i == 0) ? 1 : 0);
            check_eq("f1_fb", fb_wr_en, 1);
            check_eq("f1_busy", busy, 1);
            ov_total += out_valid; bf_total += bf_en; fd_total += frame_done;
        end
        check_eq("f1_ov_total", ov_total, 9);
        check_eq("f1_bf_total", bf_total, 9);
        check_eq("f1_fd_total", fd_total, 1);

        // Frame 2: continuous output, twiddles for legs 1/2, 3-cycle stall at cnt 12
        ov_total = 0;
        for (int i = 0; i < 3 * D; i++) begin
            if (i == 12) begin
                for (int s = 0; s < 3; s++) begin
                    step(1'b0, 1'b0);
                    check_eq("stall_bf", bf_en, 0);
                    check_eq("stall_ov", out_valid, 0);
                    check_eq("stall_fb", fb_wr_en, 0);
                    check_eq("stall_twm", tw_mult_en, 0);
                    check_eq("stall_phase", phase, 1);
                end
            end
            step(1'b1, 1'b0);
            check_eq("f2_phase", phase, i / D);
            check_eq("f2_tw", tw_idx, exp_tw(i));
            check_eq("f2_twm", tw_mult_en, (i < 2 * D) ? 1 : 0);
            check_eq("f2_bf", bf_en, (i >= 2 * D) ? 1 : 0);
            check_eq("f2_fd", frame_done, (i == 3 * D - 1) ? 1 : 0);
            ov_total += out_valid;
        end
        check_eq("f2_ov_total", ov_total, 27);

        // Frame 3: five samples, then flush with cnt=5 -> 22 pads to wrap and 18 more
        ov_total = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0);
            ov_total += out_valid;
        end
        step(1'b0, 1'b1);
        check_eq("flush_ov", out_valid, 0);
        check_eq("flush_busy", busy, 1);
        for (int j = 0; j < 40; j++) begin
            int c;
            c = (j < 22) ? (j + 5) : (j - 22);
            step((j < 4) ? 1'b1 : 1'b0, 1'b0);
            check_eq("drn_pad", pad_zero, 1);
            check_eq("drn_ov", out_valid, 1);
            check_eq("drn_phase", phase, c / D);
            check_eq("drn_tw", tw_idx, exp_tw(c));
            check_eq("drn_bf", bf_en, (c >= 2 * D) ? 1 : 0);
            check_eq("drn_fs", frame_start, 0);
            check_eq("drn_fd", frame_done, (c == 3 * D - 1) ? 1 : 0);
            check_eq("drn_busy", busy, (j == 39) ? 0 : 1);
            ov_total += out_valid;
        end
        check_eq("drn_ov_total", ov_total, 45);
        check_eq("drop_cnt", drop_cnt, EXP_DROP);
        step(1'b0, 1'b0);
        check_eq("post_drn_busy", busy, 0);
        check_eq("post_drn_pad", pad_zero, 0);
        check_eq("post_drn_ov", out_valid, 0);

        // Flush at cnt 0 with no prior frame stays idle
        step(1'b0, 1'b1);
        check_eq("idle_flush_busy", busy, 0);
        check_eq("idle_flush_ov", out_valid, 0);
        step(1'b0, 1'b0);
        check_eq("idle_flush_busy2", busy, 0);
        check_eq("idle_flush_pad", pad_zero, 0);

        // Fresh frame after drain: no previous legs remain
        for (int i = 0; i < 21; i++) begin
            step(1'b1, 1'b0);
            if (i == 0) begin
                check_eq("new_fs", frame_start, 1);
                check_eq("new_ov", out_valid, 0);
            end
        end
        check_eq("pre_rst_bf", bf_en, 1);
        check_eq("pre_rst_phase", phase, 2);

        // Asynchronous reset mid-frame
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_all_zero("arst");
        check_eq("arst_drop", drop_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 1'b0);
        check_eq("rel_fs", frame_start, 1);
        check_eq("rel_phase", phase, 0);
        check_eq("rel_ov", out_valid, 0);
        check_eq("rel_tw", tw_idx, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
